// File: rtl/cc1200_rx_pkg.sv
// Shared types and constants for the CC1200 receive unpacker: FSM states,
// default packet length and the radio status-byte field encodings.
package cc1200_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    STATUS,
    B0,
    B1,
    B2
  } rx_state_e;

  localparam int PKT_BYTES_DEF = 12;

  localparam int         CHIP_RDYN_BIT = 7;
  localparam logic [2:0] RX_FIFO_ERR   = 3'b110;

  // Radio not ready, or RX FIFO overflow/underflow reported in the state field.
  function automatic logic status_is_err(input logic [7:0] st);
    return st[CHIP_RDYN_BIT] || (st[6:4] == RX_FIFO_ERR);
  endfunction

endpackage

// File: rtl/cc1200_rx_unpack_if.sv
// Sample stream from the unpacker to the memory writer; valid/ready handshake,
// transfer happens on a clock edge where both are high.
interface cc1200_rx_unpack_if;
  logic [11:0] sample_data;
  logic        sample_sof;
  logic        sample_valid;
  logic        sample_ready;

  modport master (output sample_data, output sample_sof, output sample_valid,
                  input  sample_ready);
  modport slave  (input  sample_data, input  sample_sof, input  sample_valid,
                  output sample_ready);
endinterface

// File: rtl/cc1200_rx_fifo.sv
// First-word fall-through sample FIFO; a write lands one edge after wr_en, and
// data shows on rd_dat_o while not empty. A write into a full FIFO is accepted only alongside a read.
module cc1200_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_dat_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_dat_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int         AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_wr, do_rd;

  assign empty_o  = (wr_ptr_q == rd_ptr_q);
  assign full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_rd    = rd_en_i && !empty_o;
  assign do_wr    = wr_en_i && (!full_o || do_rd);
  assign rd_dat_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_dat_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_rd) rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end
endmodule

// File: rtl/cc1200_rx_unpack.sv
// CC1200 RX byte stream -> 12-bit samples (3 bytes -> 2), written on the edge of the completing byte;
// samples meeting a full FIFO are dropped and flagged. CC1200_RX_STATUS_EN adds rx_status/status_err.
module cc1200_rx_unpack
  import cc1200_rx_pkg::*;
#(
  parameter int PKT_BYTES  = PKT_BYTES_DEF,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                RxData,
  input  logic                      RxValid,
  input  logic                      pkt_start,
  input  logic                      pkt_end,
  cc1200_rx_unpack_if.master        smp,
  output logic [15:0]               pkt_count,
  output logic                      len_err,
  output logic                      overflow,
  input  logic                      err_clr
`ifdef CC1200_RX_STATUS_EN
  ,
  output logic [7:0]                rx_status,
  output logic                      status_err
`endif
);
  localparam logic [7:0] PKT_LEN = 8'(PKT_BYTES);

  rx_state_e   state_q, state_d;
  logic [7:0]  cnt_q, cnt_d, cnt_inc;
  logic [7:0]  b0_q, b0_d;
  logic [3:0]  b1_q, b1_d;
  logic        sof_pend_q, sof_pend_d;
  logic [15:0] pkt_count_q, pkt_count_d;
  logic        len_err_q, len_err_d, ovf_q, ovf_d;
  logic        wr_req, pkt_inc, len_set, drop;
  logic [11:0] wr_dat;
  logic        fifo_full, fifo_empty, fifo_acc;

  assign fifo_acc = !fifo_full || (smp.sample_valid && smp.sample_ready);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    b0_d       = b0_q;
    b1_d       = b1_q;
    sof_pend_d = sof_pend_q;
    wr_req     = 1'b0;
    wr_dat     = '0;
    pkt_inc    = 1'b0;
    len_set    = 1'b0;
    cnt_inc    = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    if (pkt_start) begin
      // A byte arriving with pkt_start is the new packet's status byte.
      state_d    = RxValid ? B0 : STATUS;
      cnt_d      = '0;
      b0_d       = '0;
      b1_d       = '0;
      sof_pend_d = 1'b1;
    end else begin
      if (RxValid) begin
        case (state_q)
          STATUS: state_d = B0;
          B0: begin
            b0_d    = RxData;
            cnt_d   = cnt_inc;
            state_d = B1;
          end
          B1: begin
            wr_req  = 1'b1;
            wr_dat  = {RxData[3:0], b0_q};
            b1_d    = RxData[7:4];
            cnt_d   = cnt_inc;
            state_d = B2;
          end
          B2: begin
            wr_req  = 1'b1;
            wr_dat  = {RxData, b1_q};
            cnt_d   = cnt_inc;
            state_d = (cnt_inc < PKT_LEN) ? B0 : IDLE;
          end
          default: state_d = state_q;
        endcase
      end
      if (pkt_end) begin
        if (cnt_d == PKT_LEN) pkt_inc = 1'b1;
        else                  len_set = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end
    end

    // SOF stays pending until a sample actually makes it into the FIFO.
    drop = wr_req && !fifo_acc;
    if (wr_req && fifo_acc) sof_pend_d = 1'b0;

    pkt_count_d = pkt_count_q + (pkt_inc ? 16'd1 : 16'd0);
    len_err_d   = (len_err_q && !err_clr) || len_set;
    ovf_d       = (ovf_q && !err_clr) || drop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      b0_q        <= '0;
      b1_q        <= '0;
      sof_pend_q  <= 1'b0;
      pkt_count_q <= '0;
      len_err_q   <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      b0_q        <= b0_d;
      b1_q        <= b1_d;
      sof_pend_q  <= sof_pend_d;
      pkt_count_q <= pkt_count_d;
      len_err_q   <= len_err_d;
      ovf_q       <= ovf_d;
    end
  end

  cc1200_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (13)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en_i  (wr_req),
    .wr_dat_i ({sof_pend_q, wr_dat}),
    .rd_en_i  (smp.sample_ready),
    .rd_dat_o ({smp.sample_sof, smp.sample_data}),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  assign smp.sample_valid = !fifo_empty;
  assign pkt_count        = pkt_count_q;
  assign len_err          = len_err_q;
  assign overflow         = ovf_q;

`ifdef CC1200_RX_STATUS_EN
  logic       st_take;
  logic [7:0] rx_status_q, rx_status_d;
  logic       status_err_q, status_err_d;

  assign st_take      = RxValid && (pkt_start || state_q == STATUS);
  assign rx_status_d  = st_take ? RxData : rx_status_q;
  assign status_err_d = (status_err_q && !err_clr) || (st_take && status_is_err(RxData));

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_status_q  <= '0;
      status_err_q <= 1'b0;
    end else begin
      rx_status_q  <= rx_status_d;
      status_err_q <= status_err_d;
    end
  end

  assign rx_status  = rx_status_q;
  assign status_err = status_err_q;
`endif
endmodule
